// File: rtl/antitheft_core.sv
// antitheft_core: car anti-theft controller core.
// Arming/alarm state machine, a four-entry programmable time-parameter bank,
// a half-second / one-second prescaler and a seconds countdown timer.
// Optional build macro ANTITHEFT_FUEL_PUMP_EN adds the brake / hidden_sw
// inputs and the fuel_pump output (hidden fuel-pump enable).
module antitheft_core #(
    parameter int HALF_SEC_TICKS = 25000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ignition,
    input  logic       door_driver,
    input  logic       door_pass,
    input  logic       reprogram,
    input  logic [1:0] time_param_sel,
    input  logic [3:0] time_value,
`ifdef ANTITHEFT_FUEL_PUMP_EN
    input  logic       brake,
    input  logic       hidden_sw,
    output logic       fuel_pump,
`endif
    output logic       status,
    output logic       eneble_siren,
    output logic [1:0] interval,
    output logic       start_timer,
    output logic       expired,
    output logic       one_hz_enable,
    output logic       two_hz_enable,
    output logic [3:0] counter,
    output logic [2:0] estado
);

    // State codes as seen on estado
    localparam logic [2:0] ST_ARMED       = 3'd0;
    localparam logic [2:0] ST_TRIGGERED   = 3'd1;
    localparam logic [2:0] ST_ALARM       = 3'd2;
    localparam logic [2:0] ST_ALARM_HOLD  = 3'd3;
    localparam logic [2:0] ST_DISARMED    = 3'd4;
    localparam logic [2:0] ST_WAIT_DRIVER = 3'd5;
    localparam logic [2:0] ST_WAIT_CLOSE  = 3'd6;
    localparam logic [2:0] ST_ARM_DELAY   = 3'd7;

    // Parameter indices
    localparam logic [1:0] P_ARM_DELAY    = 2'b00;
    localparam logic [1:0] P_DRIVER_DELAY = 2'b01;
    localparam logic [1:0] P_PASS_DELAY   = 2'b10;
    localparam logic [1:0] P_ALARM_ON     = 2'b11;

    // Prescaler width covers 0..HALF_SEC_TICKS-1 even for tiny bench values
    localparam int               CNT_W     = $clog2(HALF_SEC_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(HALF_SEC_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // ------------------------------------------------------------------
    // Time-parameter bank
    // ------------------------------------------------------------------
    logic [3:0] param_reg [4];
    logic [3:0] value;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_param
            localparam logic [3:0] INIT_VALUE = (gi == 0) ? 4'd6  :
                                                (gi == 1) ? 4'd8  :
                                                (gi == 2) ? 4'd15 : 4'd10;
            // Each entry resets to its factory delay and takes reprogram writes
            always_ff @(posedge clock) begin
                if (reset) begin
                    param_reg[gi] <= INIT_VALUE;
                end else if (reprogram && (time_param_sel == 2'(gi))) begin
                    param_reg[gi] <= time_value;
                end
            end
        end
    endgenerate

    logic [1:0] interval_reg;
    logic [1:0] interval_next;
    logic       start_timer_reg;
    logic       start_timer_next;

    assign value = param_reg[interval_reg];

    // ------------------------------------------------------------------
    // Prescaler: half-second and one-second strobes
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] presc_count_reg;
    logic             half_phase_reg;
    logic             two_hz_reg;
    logic             one_hz_reg;

    // Free-running tick counter; a timer start realigns it so the first
    // second of a countdown is always a full second long
    always_ff @(posedge clock) begin
        if (reset || start_timer_reg) begin
            presc_count_reg <= '0;
            half_phase_reg  <= 1'b0;
            two_hz_reg      <= 1'b0;
            one_hz_reg      <= 1'b0;
        end else if (presc_count_reg == CNT_LAST) begin
            presc_count_reg <= '0;
            half_phase_reg  <= ~half_phase_reg;
            two_hz_reg      <= 1'b1;
            one_hz_reg      <= half_phase_reg;
        end else begin
            presc_count_reg <= presc_count_reg + CNT_ONE;
            two_hz_reg      <= 1'b0;
            one_hz_reg      <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Seconds countdown timer
    // ------------------------------------------------------------------
    logic [3:0] counter_reg;
    logic       running_reg;
    logic       expired_reg;

    // Load on start, count down once per second, pulse expired on reaching 0
    always_ff @(posedge clock) begin
        if (reset) begin
            counter_reg <= 4'd0;
            running_reg <= 1'b0;
            expired_reg <= 1'b0;
        end else if (start_timer_reg) begin
            counter_reg <= value;
            running_reg <= (value != 4'd0);
            expired_reg <= (value == 4'd0);
        end else if (running_reg && one_hz_reg) begin
            counter_reg <= counter_reg - 4'd1;
            if (counter_reg == 4'd1) begin
                expired_reg <= 1'b1;
                running_reg <= 1'b0;
            end else begin
                expired_reg <= 1'b0;
            end
        end else begin
            expired_reg <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Arming / alarm state machine
    // ------------------------------------------------------------------
    logic [2:0] state_reg;
    logic [2:0] state_next;
    logic       status_reg;
    logic       status_next;
    logic       siren_reg;
    logic       siren_next;
    logic       any_door;
    logic       expired_ok;

    assign any_door   = door_driver | door_pass;
    // An expiry left over from a previous countdown is not acted on in the
    // cycle the new countdown is being loaded
    assign expired_ok = expired_reg & ~start_timer_reg;

    // Next-state, timer-interval and start-strobe decisions
    always_comb begin
        state_next       = state_reg;
        interval_next    = interval_reg;
        start_timer_next = 1'b0;
        case (state_reg)
            ST_ARMED: begin
                if (door_driver) begin
                    state_next       = ST_TRIGGERED;
                    interval_next    = P_DRIVER_DELAY;
                    start_timer_next = 1'b1;
                end else if (door_pass) begin
                    state_next       = ST_TRIGGERED;
                    interval_next    = P_PASS_DELAY;
                    start_timer_next = 1'b1;
                end
            end
            ST_TRIGGERED: begin
                if (ignition) begin
                    state_next = ST_DISARMED;
                end else if (expired_ok) begin
                    state_next = ST_ALARM;
                end
            end
            ST_ALARM: begin
                if (!any_door) begin
                    state_next       = ST_ALARM_HOLD;
                    interval_next    = P_ALARM_ON;
                    start_timer_next = 1'b1;
                end
            end
            ST_ALARM_HOLD: begin
                if (any_door) begin
                    state_next = ST_ALARM;
                end else if (expired_ok) begin
                    state_next = ST_ARMED;
                end
            end
            ST_DISARMED: begin
                if (!ignition) begin
                    state_next = ST_WAIT_DRIVER;
                end
            end
            ST_WAIT_DRIVER: begin
                if (ignition) begin
                    state_next = ST_DISARMED;
                end else if (door_driver) begin
                    state_next = ST_WAIT_CLOSE;
                end
            end
            ST_WAIT_CLOSE: begin
                if (ignition) begin
                    state_next = ST_DISARMED;
                end else if (!any_door) begin
                    state_next       = ST_ARM_DELAY;
                    interval_next    = P_ARM_DELAY;
                    start_timer_next = 1'b1;
                end
            end
            default: begin // ST_ARM_DELAY
                if (ignition) begin
                    state_next = ST_DISARMED;
                end else if (any_door) begin
                    state_next = ST_WAIT_CLOSE;
                end else if (expired_ok) begin
                    state_next = ST_ARMED;
                end
            end
        endcase
    end

    // LED and siren follow the state being entered so they line up with estado;
    // the LED blinks at 1 Hz while armed, starting dark on entry
    always_comb begin
        status_next = 1'b0;
        siren_next  = 1'b0;
        if (state_next == ST_ARMED) begin
            if (state_reg == ST_ARMED) begin
                status_next = status_reg ^ one_hz_reg;
            end
        end else begin
            status_next = (state_next == ST_TRIGGERED) ||
                          (state_next == ST_ALARM)     ||
                          (state_next == ST_ALARM_HOLD);
            siren_next  = (state_next == ST_ALARM) ||
                          (state_next == ST_ALARM_HOLD);
        end
    end

    // State registers; reprogram re-arms the system just like reset
    always_ff @(posedge clock) begin
        if (reset || reprogram) begin
            state_reg       <= ST_ARMED;
            interval_reg    <= P_ARM_DELAY;
            start_timer_reg <= 1'b0;
            status_reg      <= 1'b0;
            siren_reg       <= 1'b0;
        end else begin
            state_reg       <= state_next;
            interval_reg    <= interval_next;
            start_timer_reg <= start_timer_next;
            status_reg      <= status_next;
            siren_reg       <= siren_next;
        end
    end

`ifdef ANTITHEFT_FUEL_PUMP_EN
    // ------------------------------------------------------------------
    // Hidden fuel-pump enable
    // ------------------------------------------------------------------
    logic fuel_pump_reg;

    // Pump enabled by ignition+brake+hidden switch, dropped when ignition goes off
    always_ff @(posedge clock) begin
        if (reset || !ignition) begin
            fuel_pump_reg <= 1'b0;
        end else if (brake && hidden_sw) begin
            fuel_pump_reg <= 1'b1;
        end
    end

    assign fuel_pump = fuel_pump_reg;
`endif

    assign status        = status_reg;
    assign eneble_siren  = siren_reg;
    assign interval      = interval_reg;
    assign start_timer   = start_timer_reg;
    assign expired       = expired_reg;
    assign one_hz_enable = one_hz_reg;
    assign two_hz_enable = two_hz_reg;
    assign counter       = counter_reg;
    assign estado        = state_reg;

endmodule

// File: tb/tb_antitheft_core.sv
// tb_antitheft_core: directed-vector bench for antitheft_core with
// HALF_SEC_TICKS = 2 (one second = 4 clocks). Inputs change and outputs are
// sampled on the falling clock edge.
module tb_antitheft_core;

    logic       clock = 1'b0;
    logic       reset;
    logic       ignition;
    logic       door_driver;
    logic       door_pass;
    logic       reprogram;
    logic [1:0] time_param_sel;
    logic [3:0] time_value;
    logic       status;
    logic       eneble_siren;
    logic [1:0] interval;
    logic       start_timer;
    logic       expired;
    logic       one_hz_enable;
    logic       two_hz_enable;
    logic [3:0] counter;
    logic [2:0] estado;

    int checks = 0;
    int errors = 0;
    int n_cyc;

    antitheft_core #(.HALF_SEC_TICKS(2)) dut (
        .clock          (clock),
        .reset          (reset),
        .ignition       (ignition),
        .door_driver    (door_driver),
        .door_pass      (door_pass),
        .reprogram      (reprogram),
        .time_param_sel (time_param_sel),
        .time_value     (time_value),
        .status         (status),
        .eneble_siren   (eneble_siren),
        .interval       (interval),
        .start_timer    (start_timer),
        .expired        (expired),
        .one_hz_enable  (one_hz_enable),
        .two_hz_enable  (two_hz_enable),
        .counter        (counter),
        .estado         (estado)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Counts falling edges until expired is seen; limit+1 means it never came
    task automatic wait_expired(input int limit, output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!expired && n <= limit);
    endtask

    initial begin
        reset = 1'b1; ignition = 1'b0; door_driver = 1'b0; door_pass = 1'b0;
        reprogram = 1'b0; time_param_sel = 2'd0; time_value = 4'd0;
        step(3);
        check("rst_estado", estado, 0);
        check("rst_counter", counter, 0);
        check("rst_siren", eneble_siren, 0);
        check("rst_status", status, 0);
        check("rst_interval", interval, 0);
        check("rst_start", start_timer, 0);
        check("rst_expired", expired, 0);

        // Passenger door trigger, 15 s delay, then alarm
        reset = 1'b0; door_pass = 1'b1;
        step(1);
        check("pass_estado", estado, 1);
        check("pass_interval", interval, 2);
        check("pass_start", start_timer, 1);
        check("pass_status", status, 1);
        step(1);
        check("pass_counter", counter, 15);
        check("pass_start_drop", start_timer, 0);
        wait_expired(200, n_cyc);
        check("pass_expire_cycles", n_cyc, 61);
        step(1);
        check("alarm_estado", estado, 2);
        check("alarm_siren", eneble_siren, 1);

        // Doors closed -> hold, reopen at 5 s, close again and let it time out
        door_pass = 1'b0;
        step(1);
        check("hold_estado", estado, 3);
        check("hold_interval", interval, 3);
        check("hold_start", start_timer, 1);
        step(1);
        check("hold_counter", counter, 10);
        step(21);
        check("hold_counter_5s", counter, 5);
        door_pass = 1'b1;
        step(1);
        check("reopen_estado", estado, 2);
        door_pass = 1'b0;
        step(1);
        check("rehold_estado", estado, 3);
        step(1);
        check("rehold_counter", counter, 10);
        wait_expired(200, n_cyc);
        check("hold_expire_cycles", n_cyc, 41);
        step(1);
        check("rearm_estado", estado, 0);
        check("rearm_siren", eneble_siren, 0);
        check("rearm_status", status, 0);

        // Driver trigger, ignition at 3 s -> disarm, then re-arm sequence
        door_driver = 1'b1;
        step(1);
        check("drv_estado", estado, 1);
        check("drv_interval", interval, 1);
        step(1);
        check("drv_counter", counter, 8);
        step(13);
        check("drv_counter_3s", counter, 5);
        check("drv_no_expired", expired, 0);
        ignition = 1'b1;
        step(1);
        check("disarm_estado", estado, 4);
        check("disarm_status", status, 0);
        ignition = 1'b0;
        step(1);
        check("wait_drv_estado", estado, 5);
        step(1);
        check("wait_close_estado", estado, 6);
        door_driver = 1'b0;
        step(1);
        check("arm_delay_estado", estado, 7);
        check("arm_delay_interval", interval, 0);
        check("arm_delay_start", start_timer, 1);
        step(1);
        check("arm_delay_counter", counter, 6);
        wait_expired(200, n_cyc);
        check("arm_delay_cycles", n_cyc, 25);
        step(1);
        check("armed_estado", estado, 0);
        check("armed_status_m0", status, 0);
        step(2);
        check("armed_status_m2", status, 0);
        step(1);
        check("armed_status_m3", status, 1);
        step(4);
        check("armed_status_m7", status, 0);

        // Reprogram driver delay to 3 s; reprogram beats the door trigger
        reprogram = 1'b1; time_param_sel = 2'd1; time_value = 4'd3; door_driver = 1'b1;
        step(1);
        check("reprog_estado", estado, 0);
        check("reprog_start", start_timer, 0);
        reprogram = 1'b0;
        step(1);
        check("reprog_trig_estado", estado, 1);
        step(1);
        check("reprog_counter", counter, 3);
        wait_expired(100, n_cyc);
        check("reprog_expire_cycles", n_cyc, 13);
        step(1);
        check("reprog_alarm_estado", estado, 2);

        // Reset in the middle of the alarm
        reset = 1'b1;
        step(1);
        check("midrst_estado", estado, 0);
        check("midrst_counter", counter, 0);
        check("midrst_siren", eneble_siren, 0);
        check("midrst_status", status, 0);

        // Both doors at once -> driver delay (back to 8 after reset);
        // ignition coinciding with expired disarms
        reset = 1'b0; door_pass = 1'b1;
        step(1);
        check("both_estado", estado, 1);
        check("both_interval", interval, 1);
        step(1);
        check("param_reset_counter", counter, 8);
        wait_expired(200, n_cyc);
        check("both_expire_cycles", n_cyc, 33);
        ignition = 1'b1;
        step(1);
        check("ign_vs_expired_estado", estado, 4);
        check("ign_vs_expired_siren", eneble_siren, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/antitheft_core.md
Name: antitheft_core

Overview:
- Car anti-theft controller core: arming/alarm state machine, a programmable time-parameter bank and a seconds countdown timer.
- Inputs are the ignition, door switches and reprogram/parameter controls; outputs are the status LED, siren enable and timer/debug observables.
- Sits between debounced switch inputs and the siren/LED drivers.

Parameters:
- HALF_SEC_TICKS, 25000000, clock cycles per 0.5 s tick (50 MHz clock); benches use 2-5.

Ports:
- clock in 1: single system clock, all logic on rising edge.
- reset in 1: synchronous, active-high reset.
- ignition in 1: ignition switch on.
- door_driver in 1: driver door open.
- door_pass in 1: passenger door open.
- reprogram in 1: write time_value into parameter time_param_sel; forces ARMED.
- time_param_sel in 2: parameter index (00 ARM_DELAY, 01 DRIVER_DELAY, 10 PASSENGER_DELAY, 11 ALARM_ON).
- time_value in 4: new parameter value, seconds.
- status out 1: status LED.
- eneble_siren out 1: siren enable.
- interval out 2: parameter index currently selected for the timer.
- start_timer out 1: one-cycle timer load strobe.
- expired out 1: one-cycle countdown-finished pulse.
- one_hz_enable out 1, two_hz_enable out 1: one-cycle tick strobes.
- counter out 4: remaining seconds.
- estado out 3: state code.

Behaviour:
- Parameter bank: four 4-bit registers, reset to 6, 8, 15 and 10 (ARM_DELAY, DRIVER_DELAY, PASSENGER_DELAY, ALARM_ON). If reprogram=1 at a clock edge, the register at index time_param_sel is loaded with time_value. value = param[interval], combinational.
- Prescaler: free-running count 0..HALF_SEC_TICKS-1.
  - two_hz_enable pulses on wrap.
  - one_hz_enable pulses on every second wrap.
  - Reset or start_timer clears the count and the half-second phase.
- Timer:
  - On an edge with start_timer=1, counter <= value and the timer goes to running.
  - While running, each one_hz_enable decrements counter. On the 1->0 step, expired pulses for one cycle and running clears.
  - A start with value 0 pulses expired in the next cycle.
  - A start during running reloads the counter.
  - Reset: counter 0, idle, expired 0.
- FSM: registered state, interval and start_timer. start_timer is high exactly in the first cycle of a new timed state; expired is ignored in that cycle.
- State codes (estado):
  - 0 ARMED: status toggles on one_hz_enable; siren 0.
  - 1 TRIGGERED: status 1.
  - 2 ALARM: status 1; siren 1.
  - 3 ALARM_HOLD: status 1; siren 1.
  - 4 DISARMED.
  - 5 WAIT_DRIVER_OPEN.
  - 6 WAIT_DOOR_CLOSE.
  - 7 ARM_DELAY.
  - States 4-7: status 0, siren 0.
- Transitions:
  - ARMED: door_driver -> TRIGGERED, interval 01; else door_pass -> TRIGGERED, interval 10. Driver door has priority. Ignition alone is ignored.
  - TRIGGERED: ignition -> DISARMED (takes priority over simultaneous expired); expired -> ALARM.
  - ALARM: both doors closed -> ALARM_HOLD, interval 11, start.
  - ALARM_HOLD: any door open -> ALARM; expired -> ARMED.
  - DISARMED: ignition off -> WAIT_DRIVER_OPEN.
  - WAIT_DRIVER_OPEN: ignition -> DISARMED; door_driver -> WAIT_DOOR_CLOSE.
  - WAIT_DOOR_CLOSE: ignition -> DISARMED; both doors closed -> ARM_DELAY, interval 00, start.
  - ARM_DELAY: ignition -> DISARMED; any door open -> WAIT_DOOR_CLOSE; expired -> ARMED.
- Reset or reprogram forces ARMED, interval 00, start_timer 0, status 0, siren 0. Reprogram has priority over every transition. Reset has priority over everything.

Optional Feature:
- ANTITHEFT_FUEL_PUMP_EN defined: adds inputs brake and hidden_sw and output fuel_pump.
  - fuel_pump sets when ignition, brake and hidden_sw are all 1 at an edge.
  - fuel_pump clears when ignition=0 or on reset.
- Undefined: these ports do not exist and no pump logic is built.

Test Plan:
- Reset, HALF_SEC_TICKS=2, door_pass held 1 -> estado 0->1, interval 10, start_timer pulse, counter 15. After 15 s, expired pulse, estado 2, eneble_siren 1.
- ALARM then doors closed -> estado 3, counter 10. Door reopened at 5 s -> estado 2. Close and wait 10 s -> estado 0, siren 0.
- door_driver 1 in ARMED, ignition 1 at 3 s -> estado 4, no expired. Ignition off, driver open, close -> estado 5, 6, 7. After 6 s -> estado 0, status toggling every 1 s.
- reprogram=1, time_param_sel 01, time_value 3 -> estado 0. Driver trigger then loads counter 3 and expires after 3 s.
- door_driver and door_pass together in ARMED -> interval 01. Ignition and expired in the same cycle in TRIGGERED -> DISARMED.
- Reset asserted mid-ALARM -> next cycle estado 0, counter 0, eneble_siren 0, params back to 6/8/15/10.
